// File: rtl/ccip_mmio_responder_pkg.sv
// Shared CCI-P MMIO definitions: config header layouts, CSR offsets and the
// read-completion pipeline entry used by the responder and its delay line.
package ccip_mmio_responder_pkg;

  localparam logic [1:0] CCIP_CFG_LEN_4B = 2'd0;
  localparam logic [1:0] CCIP_CFG_LEN_8B = 2'd1;

  localparam logic [15:0] CSR_ID_L     = 16'h0000;
  localparam logic [15:0] CSR_ID_H     = 16'h0002;
  localparam logic [15:0] CSR_SCRATCH  = 16'h0004;
  localparam logic [15:0] CSR_STATUS   = 16'h0006;
  localparam logic [15:0] CSR_RD_COUNT = 16'h0008;
  localparam logic [15:0] CSR_WR_COUNT = 16'h000A;

  typedef struct packed {
    logic [7:0]  tid;
    logic [15:0] addr;
    logic [1:0]  rsvd;
    logic [1:0]  len;
  } t_ccip_cfg_req_hdr;

  typedef struct packed {
    logic       len;
    logic [7:0] tid;
  } t_ccip_cfg_rsp_hdr;

  typedef struct packed {
    logic              valid;
    t_ccip_cfg_rsp_hdr hdr;
    logic [63:0]       data;
  } t_cfg_rsp_entry;

  // Narrow a 64-bit register to the DWORD a 4B access addresses.
  function automatic logic [63:0] cfg_rd_select(input logic [63:0] full,
                                                input logic        is_8b,
                                                input logic        hi);
    logic [63:0] res;
    if (is_8b) begin
      res = full;
    end else if (hi) begin
      res = {32'h0000_0000, full[63:32]};
    end else begin
      res = {32'h0000_0000, full[31:0]};
    end
    return res;
  endfunction

endpackage

// File: rtl/ccip_mmio_rsp_pipe.sv
// Fixed-depth delay line for read completions; reset empties every stage so
// no completion survives a SoftReset.
module ccip_mmio_rsp_pipe
  import ccip_mmio_responder_pkg::*;
#(
  parameter int DEPTH = 2
) (
  input  logic           clk_i,
  input  logic           srst_i,
  input  t_cfg_rsp_entry entry_i,
  output t_cfg_rsp_entry entry_o
);

  t_cfg_rsp_entry stage_q [DEPTH];

  // Shift the completion one stage per clock.
  always_ff @(posedge clk_i) begin
    if (srst_i) begin
      for (int i = 0; i < DEPTH; i++) begin
        stage_q[i] <= '0;
      end
    end else begin
      stage_q[0] <= entry_i;
      for (int i = 1; i < DEPTH; i++) begin
        stage_q[i] <= stage_q[i-1];
      end
    end
  end

  assign entry_o = stage_q[DEPTH-1];

endmodule

// File: rtl/ccip_mmio_responder.sv
// CCI-P MMIO responder: decodes config reads/writes against a small CSR bank
// and returns read completions after a fixed latency.
module ccip_mmio_responder
  import ccip_mmio_responder_pkg::*;
#(
  parameter logic [127:0] AFU_ID     = 128'h0,
  parameter int           RD_LATENCY = 2,
  parameter int           CNT_WIDTH  = 32
) (
  input  logic        Clk_400,
  input  logic        SoftReset,
  input  logic [27:0] rx_cfg_hdr,
  input  logic        rx_cfg_rdvalid,
  input  logic        rx_cfg_wrvalid,
  input  logic [63:0] rx_cfg_wrdata,
  output logic        tx_cfg_rdvalid,
  output logic [63:0] tx_cfg_rddata,
  output logic [8:0]  tx_cfg_hdr,
  input  logic [63:0] status_set,
  output logic [63:0] status
);

  t_ccip_cfg_req_hdr    req_hdr_s;
  logic [15:0]          csr_base_s;
  logic                 is_4b_s;
  logic                 is_8b_s;
  logic                 csr_hit_s;
  logic                 mapped_s;
  logic                 unmapped_s;
  logic                 wr_en_s;
  logic [63:0]          csr_full_s;
  logic [63:0]          wr_mask_s;
  logic [63:0]          wr_val_s;
  logic [63:0]          w1c_s;
  logic                 unused_rsvd_s;
  t_cfg_rsp_entry       rsp_entry_s;
  t_cfg_rsp_entry       rsp_out_s;

  logic [63:0]          scratch_q, scratch_d;
  logic [63:0]          status_q,  status_d;
  logic [CNT_WIDTH-1:0] rd_cnt_q,  rd_cnt_d;
  logic [CNT_WIDTH-1:0] wr_cnt_q,  wr_cnt_d;

  assign req_hdr_s     = t_ccip_cfg_req_hdr'(rx_cfg_hdr);
  assign unused_rsvd_s = ^req_hdr_s.rsvd;
  assign csr_base_s    = {req_hdr_s.addr[15:1], 1'b0};
  assign is_4b_s       = (req_hdr_s.len == CCIP_CFG_LEN_4B);
  assign is_8b_s       = (req_hdr_s.len == CCIP_CFG_LEN_8B);

  // Register decode and read-side value, sampled from current state.
  always_comb begin
    csr_hit_s  = 1'b0;
    csr_full_s = 64'h0;
    case (csr_base_s)
      CSR_ID_L:     begin csr_hit_s = 1'b1; csr_full_s = AFU_ID[63:0];   end
      CSR_ID_H:     begin csr_hit_s = 1'b1; csr_full_s = AFU_ID[127:64]; end
      CSR_SCRATCH:  begin csr_hit_s = 1'b1; csr_full_s = scratch_q;      end
      CSR_STATUS:   begin csr_hit_s = 1'b1; csr_full_s = status_q;       end
      CSR_RD_COUNT: begin csr_hit_s = 1'b1; csr_full_s = 64'(rd_cnt_q);  end
      CSR_WR_COUNT: begin csr_hit_s = 1'b1; csr_full_s = 64'(wr_cnt_q);  end
      default:      begin csr_hit_s = 1'b0; csr_full_s = 64'h0;          end
    endcase
  end

  // Reserved lengths and odd-address 8B accesses never hit a register.
  assign mapped_s   = csr_hit_s & (is_4b_s | (is_8b_s & ~req_hdr_s.addr[0]));
  assign unmapped_s = (rx_cfg_rdvalid | rx_cfg_wrvalid) & ~mapped_s;
  assign wr_en_s    = rx_cfg_wrvalid & mapped_s;

  // Byte-lane mask and aligned data for the write.
  always_comb begin
    wr_mask_s = 64'h0;
    wr_val_s  = 64'h0;
    if (is_8b_s) begin
      wr_mask_s = 64'hFFFF_FFFF_FFFF_FFFF;
      wr_val_s  = rx_cfg_wrdata;
    end else if (req_hdr_s.addr[0]) begin
      wr_mask_s = {32'hFFFF_FFFF, 32'h0000_0000};
      wr_val_s  = {rx_cfg_wrdata[31:0], 32'h0000_0000};
    end else begin
      wr_mask_s = {32'h0000_0000, 32'hFFFF_FFFF};
      wr_val_s  = {32'h0000_0000, rx_cfg_wrdata[31:0]};
    end
  end

  // Next-state for the CSR bank; sets on STATUS win over same-cycle clears.
  always_comb begin
    scratch_d = scratch_q;
    w1c_s     = 64'h0;
    rd_cnt_d  = rd_cnt_q;
    wr_cnt_d  = wr_cnt_q;
    if (wr_en_s && (csr_base_s == CSR_SCRATCH)) begin
      scratch_d = (scratch_q & ~wr_mask_s) | wr_val_s;
    end else begin
      scratch_d = scratch_q;
    end
    if (wr_en_s && (csr_base_s == CSR_STATUS)) begin
      w1c_s = wr_val_s;
    end else begin
      w1c_s = 64'h0;
    end
    if (rx_cfg_rdvalid) begin
      rd_cnt_d = rd_cnt_q + {{(CNT_WIDTH-1){1'b0}}, 1'b1};
    end else begin
      rd_cnt_d = rd_cnt_q;
    end
    if (rx_cfg_wrvalid) begin
      wr_cnt_d = wr_cnt_q + {{(CNT_WIDTH-1){1'b0}}, 1'b1};
    end else begin
      wr_cnt_d = wr_cnt_q;
    end
    status_d = (status_q & ~w1c_s) | status_set | {unmapped_s, 63'h0};
  end

  // CSR state registers.
  always_ff @(posedge Clk_400) begin
    if (SoftReset) begin
      scratch_q <= 64'h0;
      status_q  <= 64'h0;
      rd_cnt_q  <= '0;
      wr_cnt_q  <= '0;
    end else begin
      scratch_q <= scratch_d;
      status_q  <= status_d;
      rd_cnt_q  <= rd_cnt_d;
      wr_cnt_q  <= wr_cnt_d;
    end
  end

  // Build the completion at the request cycle so data reflects pre-write state.
  always_comb begin
    rsp_entry_s = '0;
    if (rx_cfg_rdvalid) begin
      rsp_entry_s.valid   = 1'b1;
      rsp_entry_s.hdr.len = is_8b_s;
      rsp_entry_s.hdr.tid = req_hdr_s.tid;
      if (mapped_s) begin
        rsp_entry_s.data = cfg_rd_select(csr_full_s, is_8b_s, req_hdr_s.addr[0]);
      end else begin
        rsp_entry_s.data = 64'h0;
      end
    end else begin
      rsp_entry_s = '0;
    end
  end

  ccip_mmio_rsp_pipe #(
    .DEPTH (RD_LATENCY)
  ) u_rsp_pipe (
    .clk_i   (Clk_400),
    .srst_i  (SoftReset),
    .entry_i (rsp_entry_s),
    .entry_o (rsp_out_s)
  );

  assign tx_cfg_rdvalid = rsp_out_s.valid;
  assign tx_cfg_rddata  = rsp_out_s.data;
  assign tx_cfg_hdr     = rsp_out_s.hdr;
  assign status         = status_q;

endmodule

// File: tb/tb_ccip_mmio_responder.sv
// Randomised scoreboard bench for ccip_mmio_responder against a register-level
// reference model held in plain variables.
module tb_ccip_mmio_responder;

  localparam logic [127:0] AFU_ID = 128'hA55A_0123_4567_89AB_CDEF_FEDC_BA98_7601;
  localparam int LAT = 2;

  logic        clk = 1'b0;
  logic        srst = 1'b1;
  logic [27:0] rx_hdr = 28'h0;
  logic        rx_rd = 1'b0;
  logic        rx_wr = 1'b0;
  logic [63:0] rx_wd = 64'h0;
  logic        tx_valid;
  logic [63:0] tx_data;
  logic [8:0]  tx_hdr;
  logic [63:0] st_set = 64'h0;
  logic [63:0] st_out;

  int checks = 0;
  int errors = 0;
  int unsigned cyc = 0;

  typedef struct {
    int unsigned due;
    logic [8:0]  hdr;
    logic [63:0] data;
  } exp_t;
  exp_t exp_q[$];

  logic [63:0] m_scratch = 64'h0;
  logic [63:0] m_status  = 64'h0;
  logic [31:0] m_rd      = 32'h0;
  logic [31:0] m_wr      = 32'h0;

  ccip_mmio_responder #(
    .AFU_ID     (AFU_ID),
    .RD_LATENCY (LAT),
    .CNT_WIDTH  (32)
  ) dut (
    .Clk_400        (clk),
    .SoftReset      (srst),
    .rx_cfg_hdr     (rx_hdr),
    .rx_cfg_rdvalid (rx_rd),
    .rx_cfg_wrvalid (rx_wr),
    .rx_cfg_wrdata  (rx_wd),
    .tx_cfg_rdvalid (tx_valid),
    .tx_cfg_rddata  (tx_data),
    .tx_cfg_hdr     (tx_hdr),
    .status_set     (st_set),
    .status         (st_out)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  function automatic logic [27:0] mk_hdr(input logic [7:0] tid, input logic [15:0] addr,
                                         input logic [1:0] len);
    return {tid, addr, 2'b00, len};
  endfunction

  // Completion monitor: every presented completion is matched to the oldest expectation.
  always @(negedge clk) begin
    if (tx_valid) begin
      checks++;
      if (exp_q.size() == 0) begin
        errors++;
        $display("FAIL unexpected_rsp: cyc=%0d hdr=%h data=%h, none expected", cyc, tx_hdr, tx_data);
      end else begin
        exp_t e;
        e = exp_q.pop_front();
        if (tx_data !== e.data || tx_hdr !== e.hdr || cyc != e.due) begin
          errors++;
          $display("FAIL rd_rsp: got hdr=%h data=%h at cyc %0d, expected hdr=%h data=%h at cyc %0d",
                   tx_hdr, tx_data, cyc, e.hdr, e.data, e.due);
        end
      end
    end else if (exp_q.size() != 0 && exp_q[0].due <= cyc) begin
      exp_t e;
      e = exp_q.pop_front();
      checks++;
      errors++;
      $display("FAIL missing_rsp: no completion at cyc %0d, expected hdr=%h data=%h", cyc, e.hdr, e.data);
    end
  end

  // One clock of stimulus: check STATUS against the model, drive, then advance the model.
  task automatic step(input logic rd, input logic wr, input logic [27:0] hdr,
                      input logic [63:0] wd, input logic [63:0] set, input logic rst);
    logic [7:0]  tid;
    logic [15:0] addr;
    logic [1:0]  len;
    logic        mapped;
    logic [63:0] regs [6];
    logic [63:0] full, rdata, mask, val;
    int          idx, sh;
    exp_t        e;
    exp_t        keep[$];
    @(negedge clk);
    checks++;
    if (st_out !== m_status) begin
      errors++;
      $display("FAIL status: got %h expected %h at cyc %0d", st_out, m_status, cyc);
    end
    srst   = rst;
    rx_rd  = rd;
    rx_wr  = wr;
    rx_hdr = hdr;
    rx_wd  = wd;
    st_set = set;
    if (rst) begin
      foreach (exp_q[i]) if (exp_q[i].due <= cyc) keep.push_back(exp_q[i]);
      exp_q = keep;
      m_scratch = 64'h0; m_status = 64'h0; m_rd = 32'h0; m_wr = 32'h0;
    end else begin
      tid  = hdr[27:20];
      addr = hdr[19:4];
      len  = hdr[1:0];
      idx  = int'(addr) / 2;
      mapped = (addr < 16'd12) && (len == 2'd0 || (len == 2'd1 && addr[0] == 1'b0));
      regs = '{AFU_ID[63:0], AFU_ID[127:64], m_scratch, m_status, {32'h0, m_rd}, {32'h0, m_wr}};
      full = mapped ? regs[idx] : 64'h0;
      sh   = addr[0] ? 32 : 0;
      if (len == 2'd1) rdata = full;
      else rdata = (full >> sh) & 64'h0000_0000_FFFF_FFFF;
      if (rd) begin
        e.due  = cyc + LAT;
        e.hdr  = {len == 2'd1, tid};
        e.data = rdata;
        exp_q.push_back(e);
      end
      mask = (len == 2'd1) ? 64'hFFFF_FFFF_FFFF_FFFF : (64'h0000_0000_FFFF_FFFF << sh);
      val  = (len == 2'd1) ? wd : ({32'h0, wd[31:0]} << sh);
      if (wr && mapped && idx == 2) m_scratch = (m_scratch & ~mask) | val;
      m_status = m_status & ~((wr && mapped && idx == 3) ? val : 64'h0);
      m_status = m_status | set;
      if ((rd || wr) && !mapped) m_status[63] = 1'b1;
      if (rd) m_rd = m_rd + 32'd1;
      if (wr) m_wr = m_wr + 32'd1;
    end
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) step(1'b0, 1'b0, 28'h0, 64'h0, 64'h0, 1'b0);
  endtask

  task automatic check_idle_outputs(input string name);
    checks++;
    if (tx_valid !== 1'b0 || tx_data !== 64'h0 || tx_hdr !== 9'h0 || st_out !== 64'h0) begin
      errors++;
      $display("FAIL %s: valid=%b data=%h hdr=%h status=%h, all zero expected",
               name, tx_valid, tx_data, tx_hdr, st_out);
    end
  endtask

  initial begin
    logic [15:0] a;
    logic [1:0]  l;
    int          r;
    repeat (3) @(negedge clk);
    check_idle_outputs("reset_state");
    // Model starts at reset values; keep reset asserted one more modelled cycle.
    step(1'b0, 1'b0, 28'h0, 64'h0, 64'h0, 1'b1);

    step(1'b1, 1'b0, mk_hdr(8'h11, 16'h0000, 2'd1), 64'h0, 64'h0, 1'b0);
    step(1'b0, 1'b1, mk_hdr(8'h00, 16'h0004, 2'd1), 64'hDEAD_BEEF_0123_4567, 64'h0, 1'b0);
    step(1'b1, 1'b0, mk_hdr(8'h22, 16'h0005, 2'd0), 64'h0, 64'h0, 1'b0);
    step(1'b1, 1'b0, mk_hdr(8'h01, 16'h0000, 2'd1), 64'h0, 64'h0, 1'b0);
    step(1'b1, 1'b0, mk_hdr(8'h02, 16'h0002, 2'd1), 64'h0, 64'h0, 1'b0);
    step(1'b1, 1'b0, mk_hdr(8'h03, 16'h0004, 2'd1), 64'h0, 64'h0, 1'b0);
    step(1'b1, 1'b0, mk_hdr(8'h04, 16'h0008, 2'd1), 64'h0, 64'h0, 1'b0);
    step(1'b0, 1'b1, mk_hdr(8'h00, 16'h0006, 2'd1), 64'h1, 64'h1, 1'b0);
    idle(2);
    step(1'b0, 1'b1, mk_hdr(8'h00, 16'h0006, 2'd1), 64'h1, 64'h0, 1'b0);
    step(1'b1, 1'b0, mk_hdr(8'h05, 16'h0040, 2'd0), 64'h0, 64'h0, 1'b0);
    step(1'b1, 1'b0, mk_hdr(8'h06, 16'h0005, 2'd1), 64'h0, 64'h0, 1'b0);
    step(1'b1, 1'b0, mk_hdr(8'h07, 16'h000A, 2'd1), 64'h0, 64'h0, 1'b0);
    step(1'b1, 1'b1, mk_hdr(8'h08, 16'h0004, 2'd1), 64'h1234_5678_9ABC_DEF0, 64'h0, 1'b0);
    step(1'b1, 1'b0, mk_hdr(8'h09, 16'h0004, 2'd1), 64'h0, 64'h0, 1'b0);
    step(1'b0, 1'b1, mk_hdr(8'h00, 16'h0006, 2'd1), 64'h8000_0000_0000_0000, 64'h0, 1'b0);
    idle(3);

    for (int i = 0; i < 600; i++) begin
      r = $urandom_range(0, 15);
      a = (r < 14) ? 16'(r) : 16'(16'h0040 + $urandom_range(0, 3));
      r = $urandom_range(0, 9);
      l = (r < 4) ? 2'd0 : (r < 8) ? 2'd1 : 2'(r - 6);
      step(($urandom_range(0, 2) != 0), ($urandom_range(0, 2) == 0),
           mk_hdr(8'($urandom), a, l), {$urandom, $urandom},
           ($urandom_range(0, 5) == 0) ? ({$urandom, $urandom} & {$urandom, $urandom}) : 64'h0,
           1'b0);
    end
    idle(LAT + 2);

    step(1'b1, 1'b0, mk_hdr(8'h33, 16'h0002, 2'd1), 64'h0, 64'h0, 1'b0);
    step(1'b1, 1'b1, mk_hdr(8'h34, 16'h0004, 2'd1), 64'hFFFF_0000_FFFF_0000, 64'hFF, 1'b1);
    step(1'b0, 1'b0, 28'h0, 64'h0, 64'h0, 1'b1);
    step(1'b0, 1'b0, 28'h0, 64'h0, 64'h0, 1'b0);
    check_idle_outputs("after_reset");
    idle(LAT + 3);
    check_idle_outputs("after_reset_drain");
    step(1'b1, 1'b0, mk_hdr(8'h44, 16'h0004, 2'd1), 64'h0, 64'h0, 1'b0);
    step(1'b1, 1'b0, mk_hdr(8'h45, 16'h0008, 2'd1), 64'h0, 64'h0, 1'b0);
    idle(LAT + 4);

    checks++;
    if (exp_q.size() != 0) begin
      errors++;
      $display("FAIL drain: %0d completions outstanding, 0 expected", exp_q.size());
    end
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
